// File: rtl/rob_fill_writer.sv
// ROB fill producer: round-robin arbiter for two units in front of a small result FIFO.
// Optional ROB_FILL_STALL_CNT_EN adds a saturating stall_cnt output.
module rob_fill_writer #(
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [ROB_IDX_W-1:0]   a_idx,
    input  logic [DATA_W-1:0]      a_data,
    input  logic                   a_exc,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [ROB_IDX_W-1:0]   b_idx,
    input  logic [DATA_W-1:0]      b_data,
    input  logic                   b_exc,
    input  logic                   flush,
    output logic                   fill_valid,
    input  logic                   fill_ready,
    output logic [ROB_IDX_W-1:0]   fill_idx,
    output logic [DATA_W-1:0]      fill_data,
    output logic                   fill_exc,
    output logic [$clog2(DEPTH):0] occ
`ifdef ROB_FILL_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    data;
        logic                 exc;
    } entry_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    src_e       prio;
    src_e       grant;
    entry_t     wr_entry;
    logic       full;
    logic       empty;
    logic       can_push;
    logic       push;
    logic       pop;
    logic       both_valid;

    assign full       = (occ == OCC_W'(DEPTH));
    assign empty      = (occ == '0);
    assign both_valid = a_valid && b_valid;

    always_comb begin
        grant = SRC_A;
        if (both_valid) begin
            grant = prio;
        end else if (b_valid) begin
            grant = SRC_B;
        end
    end

    // Readiness ignores fill_ready so a full FIFO never takes a push.
    assign can_push = !full && !flush && !rst;
    assign a_ready  = (grant == SRC_A) && can_push;
    assign b_ready  = (grant == SRC_B) && can_push;
    assign push     = (a_valid && a_ready) || (b_valid && b_ready);

    always_comb begin
        wr_entry = '{idx: a_idx, data: a_data, exc: a_exc};
        if (grant == SRC_B) begin
            wr_entry = '{idx: b_idx, data: b_data, exc: b_exc};
        end
    end

    assign fill_valid = !empty && !flush && !rst;
    assign pop        = fill_valid && fill_ready;
    assign fill_idx   = mem[rd_ptr].idx;
    assign fill_data  = mem[rd_ptr].data;
    assign fill_exc   = mem[rd_ptr].exc;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            prio   <= SRC_A;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            // Only a contended push rotates priority.
            if (push && both_valid) begin
                prio <= (prio == SRC_A) ? SRC_B : SRC_A;
            end
        end
    end

`ifdef ROB_FILL_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (fill_valid && !fill_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_fill_writer.sv
// Directed self-checking bench for rob_fill_writer.
module tb_rob_fill_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_idx = '0;
    logic [31:0] a_data = '0;
    logic        a_exc = 1'b0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_idx = '0;
    logic [31:0] b_data = '0;
    logic        b_exc = 1'b0;
    logic        flush = 1'b0;
    logic        fill_valid;
    logic        fill_ready = 1'b0;
    logic [4:0]  fill_idx;
    logic [31:0] fill_data;
    logic        fill_exc;
    logic [2:0]  occ;
`ifdef ROB_FILL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_fill_writer #(
        .ROB_IDX_W(5),
        .DATA_W(32),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_idx(a_idx),
        .a_data(a_data),
        .a_exc(a_exc),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_idx(b_idx),
        .b_data(b_data),
        .b_exc(b_exc),
        .flush(flush),
        .fill_valid(fill_valid),
        .fill_ready(fill_ready),
        .fill_idx(fill_idx),
        .fill_data(fill_data),
        .fill_exc(fill_exc),
`ifdef ROB_FILL_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .occ(occ)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got a=%b b=%b exp 0 0", a_ready, b_ready);
        end
        checks++;
        if (fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fill_valid got %b exp 0", fill_valid);
        end
        tick();
        tick();
        checks++;
        if (occ !== 3'd0) begin
            errors++;
            $display("FAIL reset_occ got %0d exp 0", occ);
        end
        rst = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        checks++;
        if (fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_fill_valid got %b exp 0", fill_valid);
        end
    endtask

    task automatic test_single;
        fill_ready = 1'b1;
        a_valid = 1'b1;
        a_idx = 5'd3;
        a_data = 32'hDEADBEEF;
        a_exc = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_push got rdy=%b fv=%b exp 1 0", a_ready, fill_valid);
        end
        tick();
        a_valid = 1'b0;
        #1;
        checks++;
        if (fill_valid !== 1'b1 || fill_idx !== 5'd3 ||
            fill_data !== 32'hDEADBEEF || fill_exc !== 1'b0) begin
            errors++;
            $display("FAIL single_out got fv=%b idx=%0d data=%h exc=%b exp 1 3 deadbeef 0",
                     fill_valid, fill_idx, fill_data, fill_exc);
        end
        tick();
        checks++;
        if (occ !== 3'd0 || fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got occ=%0d fv=%b exp 0 0", occ, fill_valid);
        end
    endtask

    task automatic test_contention;
        logic exp_a;
        logic [4:0] exp_idx;
        fill_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1;
            b_valid = 1'b1;
            a_idx = 5'd5;
            b_idx = 5'd9;
            #1;
            exp_a = (i % 2 == 0);
            checks++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                errors++;
                $display("FAIL rr_grant%0d got a=%b b=%b exp a=%b", i, a_ready, b_ready, exp_a);
            end
            if (i > 0) begin
                exp_idx = (i % 2 == 1) ? 5'd5 : 5'd9;
                checks++;
                if (fill_valid !== 1'b1 || fill_idx !== exp_idx) begin
                    errors++;
                    $display("FAIL rr_order%0d got fv=%b idx=%0d exp 1 %0d",
                             i, fill_valid, fill_idx, exp_idx);
                end
            end
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        checks++;
        if (fill_idx !== 5'd9) begin
            errors++;
            $display("FAIL rr_last got idx=%0d exp 9", fill_idx);
        end
        tick();
        checks++;
        if (occ !== 3'd0) begin
            errors++;
            $display("FAIL rr_drain got occ=%0d exp 0", occ);
        end
    endtask

    task automatic test_full;
        fill_ready = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_idx = 5'(10 + i);
            a_data = 32'(100 + i);
            #1;
            checks++;
            if (a_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_accept%0d got %b exp 1", i, a_ready);
            end
            tick();
        end
        a_idx = 5'd14;
        a_data = 32'd114;
        #1;
        checks++;
        if (a_ready !== 1'b0 || occ !== 3'd4 || fill_idx !== 5'd10) begin
            errors++;
            $display("FAIL full_state got rdy=%b occ=%0d idx=%0d exp 0 4 10",
                     a_ready, occ, fill_idx);
        end
        fill_ready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_no_push got rdy=%b exp 0", a_ready);
        end
        tick();
        checks++;
        if (a_ready !== 1'b1 || occ !== 3'd3 || fill_idx !== 5'd11) begin
            errors++;
            $display("FAIL full_refill got rdy=%b occ=%0d idx=%0d exp 1 3 11",
                     a_ready, occ, fill_idx);
        end
        tick();
        a_valid = 1'b0;
        #1;
        checks++;
        if (occ !== 3'd3 || fill_idx !== 5'd12) begin
            errors++;
            $display("FAIL full_pushpop got occ=%0d idx=%0d exp 3 12", occ, fill_idx);
        end
        tick();
        checks++;
        if (fill_idx !== 5'd13) begin
            errors++;
            $display("FAIL full_drain13 got idx=%0d exp 13", fill_idx);
        end
        tick();
        checks++;
        if (fill_idx !== 5'd14 || fill_data !== 32'd114) begin
            errors++;
            $display("FAIL full_drain14 got idx=%0d data=%0d exp 14 114", fill_idx, fill_data);
        end
        tick();
        checks++;
        if (occ !== 3'd0) begin
            errors++;
            $display("FAIL full_empty got occ=%0d exp 0", occ);
        end
    endtask

    task automatic test_stall;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fill_ready = 1'b0;
        a_valid = 1'b1;
        a_idx = 5'd7;
        a_data = 32'h1234;
        a_exc = 1'b1;
        tick();
        a_valid = 1'b0;
        a_exc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (fill_valid !== 1'b1 || fill_idx !== 5'd7 ||
                fill_data !== 32'h1234 || fill_exc !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got fv=%b idx=%0d data=%h exc=%b exp 1 7 1234 1",
                         k, fill_valid, fill_idx, fill_data, fill_exc);
            end
            tick();
        end
`ifdef ROB_FILL_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_cnt got %0d exp 3", stall_cnt);
        end
`endif
        fill_ready = 1'b1;
        tick();
        checks++;
        if (occ !== 3'd0) begin
            errors++;
            $display("FAIL stall_drain got occ=%0d exp 0", occ);
        end
    endtask

    task automatic test_flush;
        fill_ready = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_idx = 5'(20 + i);
            tick();
        end
        a_idx = 5'd23;
        flush = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0 || fill_valid !== 1'b0 || occ !== 3'd3) begin
            errors++;
            $display("FAIL flush_cycle got rdy=%b fv=%b occ=%0d exp 0 0 3",
                     a_ready, fill_valid, occ);
        end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (occ !== 3'd0 || fill_valid !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after got occ=%0d fv=%b rdy=%b exp 0 0 1",
                     occ, fill_valid, a_ready);
        end
        tick();
        a_valid = 1'b0;
        #1;
        checks++;
        if (occ !== 3'd1 || fill_valid !== 1'b1 || fill_idx !== 5'd23) begin
            errors++;
            $display("FAIL flush_accept got occ=%0d fv=%b idx=%0d exp 1 1 23",
                     occ, fill_valid, fill_idx);
        end
        fill_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid;
        fill_ready = 1'b0;
        a_valid = 1'b1;
        a_idx = 5'd2;
        tick();
        a_valid = 1'b0;
        #1;
        checks++;
        if (fill_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_held got fv=%b exp 1", fill_valid);
        end
        rst = 1'b1;
        fill_ready = 1'b1;
        #1;
        checks++;
        if (fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop got fv=%b exp 0", fill_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (occ !== 3'd0 || fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after got occ=%0d fv=%b exp 0 0", occ, fill_valid);
        end
    endtask

    task automatic test_wrap;
        fill_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            a_valid = 1'b1;
            a_data = 32'(i);
            a_idx = 5'(i);
            #1;
            if (i > 1) begin
                checks++;
                if (fill_data !== 32'(i - 1) || occ !== 3'd1) begin
                    errors++;
                    $display("FAIL wrap%0d got data=%0d occ=%0d exp %0d 1",
                             i, fill_data, occ, i - 1);
                end
            end
            tick();
        end
        a_valid = 1'b0;
        #1;
        checks++;
        if (fill_data !== 32'd10 || fill_idx !== 5'd10) begin
            errors++;
            $display("FAIL wrap_last got data=%0d idx=%0d exp 10 10", fill_data, fill_idx);
        end
        tick();
        checks++;
        if (occ !== 3'd0) begin
            errors++;
            $display("FAIL wrap_drain got occ=%0d exp 0", occ);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_stall();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
